// File: rtl/piso_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module      : piso_bit_feeder
// Description : Parallel-in/serial-out feeder with gap-free back-to-back
//               words, driving the xin input of a serial pattern detector.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             xout,
  output logic             xout_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
    $error("piso_bit_feeder: WIDTH must be in 2..32");
  end

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               last_bit;
  logic               accept;

  assign last_bit  = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
  assign din_ready = rst && ((state_q == S_IDLE) || last_bit);
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SHIFT;
          shreg_d = din;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        if (!last_bit) begin
          if (MSB_FIRST) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          end else begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else if (accept) begin
          shreg_d = din;
          cnt_d   = '0;
        end else begin
          // Clearing the register keeps the registered xout at 0 while idle.
          state_d = S_IDLE;
          shreg_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  if (MSB_FIRST) begin : g_msb_first
    assign xout = shreg_q[WIDTH-1];
  end else begin : g_lsb_first
    assign xout = shreg_q[0];
  end

  assign xout_valid = (state_q == S_SHIFT);
  assign busy       = (state_q == S_SHIFT);
  assign word_done  = last_bit;

endmodule
`default_nettype wire

// File: tb/tb_piso_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_bit_feeder
// Description : Directed vector bench for piso_bit_feeder (8-bit MSB-first
//               instance plus a 5-bit LSB-first instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_bit_feeder;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, xout, xout_valid, busy, word_done;

  logic       rst_b;
  logic [4:0] din_b;
  logic       din_valid_b;
  logic       din_ready_b, xout_b, xout_valid_b, busy_b, word_done_b;

  int n_cmp = 0;
  int n_bad = 0;

  piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .xout(xout), .xout_valid(xout_valid), .busy(busy), .word_done(word_done)
  );

  piso_bit_feeder #(.WIDTH(5), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst(rst_b), .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
    .xout(xout_b), .xout_valid(xout_valid_b), .busy(busy_b), .word_done(word_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [7:0] d;
    logic       v;
    logic       xo;
    logic       xv;
    logic       bz;
    logic       wd;
    logic       rdy;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic r, logic [7:0] d, logic v,
                              logic xo, logic xv, logic bz, logic wd, logic rdy);
    vec_t e;
    e.r = r; e.d = d; e.v = v;
    e.xo = xo; e.xv = xv; e.bz = bz; e.wd = wd; e.rdy = rdy;
    vq.push_back(e);
  endfunction

  function automatic void add_idle(logic [7:0] d, logic v);
    add(1'b1, d, v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  // Eight shifting cycles of word w, MSB first; the last cycle is the handoff.
  function automatic void add_word(logic [7:0] w, logic [7:0] d_first,
                                   logic [7:0] d_rest, logic v);
    for (int i = 0; i < 8; i++) begin
      add(1'b1, (i == 0) ? d_first : d_rest, v,
          w[7-i], 1'b1, 1'b1, (i == 7), (i == 7));
    end
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [4:0] exp_b;
  logic [4:0] hist;

  initial begin
    rst = 1'b0; din = '0; din_valid = 1'b0;
    rst_b = 1'b0; din_b = '0; din_valid_b = 1'b0;
    hist = '0;

    // reset
    add(1'b0, 8'h00, 1'b0, 0, 0, 0, 0, 0);
    add(1'b0, 8'h00, 1'b1, 0, 0, 0, 0, 0);
    // single word 0x55
    add_idle(8'h55, 1'b1);
    add_word(8'h55, 8'h55, 8'h55, 1'b0);
    add_idle(8'h00, 1'b0);
    // back-to-back A5 then 3C, valid held high
    add_idle(8'hA5, 1'b1);
    add_word(8'hA5, 8'h3C, 8'h3C, 1'b1);
    add_word(8'h3C, 8'h00, 8'h00, 1'b0);
    add_idle(8'h00, 1'b0);
    // din changes to FF while busy; FF taken only at the handoff
    add_idle(8'h96, 1'b1);
    add_word(8'h96, 8'h96, 8'hFF, 1'b1);
    add_word(8'hFF, 8'h00, 8'h00, 1'b0);
    add_idle(8'h00, 1'b0);
    // reset in the middle of F0
    add_idle(8'hF0, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1, 1, 1, 0, 0);
    add(1'b1, 8'h00, 1'b0, 1, 1, 1, 0, 0);
    add(1'b1, 8'h00, 1'b0, 1, 1, 1, 0, 0);
    add(1'b0, 8'h00, 1'b1, 0, 0, 0, 0, 0);
    add(1'b0, 8'h00, 1'b1, 0, 0, 0, 0, 0);
    add_idle(8'hC3, 1'b1);
    add_word(8'hC3, 8'h00, 8'h00, 1'b0);
    add_idle(8'h00, 1'b0);
    // three idle cycles between 0A and 50
    add_idle(8'h0A, 1'b1);
    add_word(8'h0A, 8'h00, 8'h00, 1'b0);
    add_idle(8'h00, 1'b0);
    add_idle(8'h00, 1'b0);
    add_idle(8'h50, 1'b1);
    add_word(8'h50, 8'h00, 8'h00, 1'b0);
    add_idle(8'h00, 1'b0);

    for (int j = 0; j < vq.size(); j++) begin
      @(posedge clk);
      #1;
      rst       = vq[j].r;
      din       = vq[j].d;
      din_valid = vq[j].v;
      @(negedge clk);
      chk($sformatf("v%0d xout", j),       32'(xout),       32'(vq[j].xo));
      chk($sformatf("v%0d xout_valid", j), 32'(xout_valid), 32'(vq[j].xv));
      chk($sformatf("v%0d busy", j),       32'(busy),       32'(vq[j].bz));
      chk($sformatf("v%0d word_done", j),  32'(word_done),  32'(vq[j].wd));
      chk($sformatf("v%0d din_ready", j),  32'(din_ready),  32'(vq[j].rdy));
    end

    // 5-bit LSB-first instance carrying 01010 into a 5-bit history window
    exp_b = 5'b01010;
    @(negedge clk);
    chk("lsb reset xout_valid", 32'(xout_valid_b), 32'd0);
    chk("lsb reset din_ready",  32'(din_ready_b),  32'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b1; din_b = 5'b01010; din_valid_b = 1'b1;
    @(negedge clk);
    chk("lsb idle din_ready", 32'(din_ready_b), 32'd1);
    @(posedge clk);
    #1;
    din_valid_b = 1'b0; din_b = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      chk($sformatf("lsb bit%0d xout", i),      32'(xout_b),       32'(exp_b[i]));
      chk($sformatf("lsb bit%0d valid", i),     32'(xout_valid_b), 32'd1);
      chk($sformatf("lsb bit%0d word_done", i), 32'(word_done_b),  32'(i == 4));
      hist = {hist[3:0], xout_b};
    end
    chk("lsb detector window", 32'(hist), 32'(5'b01010));
    @(posedge clk);
    @(negedge clk);
    chk("lsb after xout_valid", 32'(xout_valid_b), 32'd0);
    chk("lsb after xout",       32'(xout_b),       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
